// File: rtl/delete_event_queue.sv
// Timestamped FIFO of Delete Order events with first-word-fall-through output and sticky overflow.
// Define DELETE_QUEUE_STATS_EN to add saturating accepted/dropped event counters.
module delete_event_queue #(
    parameter int DEPTH    = 8,
    parameter int TS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     delete_internal_valid,
    input  logic                     delete_packet_invalid,
    input  logic [63:0]              delete_order_ref,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_order_ref,
    output logic [TS_WIDTH-1:0]      out_timestamp,
    output logic                     overflow,
    input  logic                     overflow_clr,
    output logic [$clog2(DEPTH):0]   level
`ifdef DELETE_QUEUE_STATS_EN
    ,
    output logic [31:0]              accepted_count,
    output logic [31:0]              dropped_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    // Handshake: an entry transfers out when out_valid && out_ready on a rising clk;
    // out_valid depends only on stored occupancy, never on out_ready.
    logic [AW-1:0]          rd_ptr;
    logic [AW-1:0]          wr_ptr;
    logic [TS_WIDTH-1:0]    ts_count;
    logic [TS_WIDTH+63:0]   mem [DEPTH];
    logic [TS_WIDTH+63:0]   head;

    logic full;
    logic push_req;
    logic pop;
    logic do_push;
    logic drop;

    assign full     = (level == FULL_LEVEL);
    assign push_req = delete_internal_valid && !delete_packet_invalid;
    assign pop      = out_valid && out_ready;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign do_push  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            ts_count <= '0;
            overflow <= 1'b0;
        end else begin
            ts_count <= ts_count + 1'b1;
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop)              overflow <= 1'b1;
            else if (overflow_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !rst) mem[wr_ptr] <= {ts_count, delete_order_ref};
    end

    assign head          = mem[rd_ptr];
    assign out_valid     = (level != '0);
    assign out_order_ref = out_valid ? head[63:0] : 64'd0;
    assign out_timestamp = out_valid ? head[TS_WIDTH+63:64] : '0;

`ifdef DELETE_QUEUE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            accepted_count <= '0;
            dropped_count  <= '0;
        end else begin
            if (do_push && accepted_count != '1) accepted_count <= accepted_count + 1'b1;
            if (drop && dropped_count != '1)     dropped_count  <= dropped_count + 1'b1;
        end
    end
`endif

endmodule

// File: doc/delete_event_queue.md
DELETE_EVENT_QUEUE -- requirements
Module: delete_event_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, queue entries; power of two, minimum 2.
REQ-002 SHALL have parameter TS_WIDTH, default 32, width of the cycle-timestamp field.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on posedge clk.
REQ-004 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port delete_internal_valid, input, 1, one-cycle pulse from the Delete Order decoder marking a complete message.
REQ-006 SHALL have port delete_packet_invalid, input, 1, decoder malformed-message flag.
REQ-007 SHALL have port delete_order_ref, input, 64, parsed order reference, sampled when delete_internal_valid=1.
REQ-008 SHALL have port out_valid, output, 1, head entry available.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts head entry.
REQ-010 SHALL have port out_order_ref, output, 64, head entry order reference.
REQ-011 SHALL have port out_timestamp, output, TS_WIDTH, head entry capture time.
REQ-012 SHALL have port overflow, output, 1, sticky flag set when an event is dropped on full.
REQ-013 SHALL have port overflow_clr, input, 1, clears overflow.
REQ-014 SHALL have port level, output, $clog2(DEPTH)+1, current occupancy.

Function
REQ-015 SHALL run a free-running TS_WIDTH counter, incremented every non-reset cycle, wrapping to 0 at all-ones.
REQ-016 SHALL treat a cycle as a push request when delete_internal_valid=1 and delete_packet_invalid=0.
REQ-017 SHALL discard the event, without setting overflow, when delete_internal_valid=1 and delete_packet_invalid=1 in the same cycle.
REQ-018 SHALL store {timestamp counter value of the push cycle, delete_order_ref} at the write pointer on a push request.
REQ-019 SHALL pop the head entry when out_valid=1 and out_ready=1.
REQ-020 SHALL assert out_valid exactly when level>0; first-word-fall-through; an entry pushed in cycle N appears on the outputs in cycle N+1 if the queue was empty.
REQ-021 SHALL hold out_order_ref and out_timestamp stable while out_valid=1 and out_ready=0.
REQ-022 SHALL ignore out_ready when empty; level and pointers SHALL NOT change.
REQ-023 SHALL accept a push when full if a pop occurs the same cycle; level SHALL remain DEPTH.
REQ-024 SHALL drop a push when full without a pop, set overflow the next cycle, and leave queue contents unchanged.
REQ-025 SHALL keep level unchanged on simultaneous push and pop when 0<level<DEPTH.
REQ-026 SHALL wrap read and write pointers modulo DEPTH.
REQ-027 SHALL give set priority over overflow_clr when a drop and overflow_clr coincide.
REQ-028 SHALL drive out_order_ref and out_timestamp to 0 while out_valid=0.

Reset
REQ-029 SHALL on rst=1 clear pointers, level, timestamp counter, overflow, out_valid, out_order_ref and out_timestamp to 0 in the next cycle.
REQ-030 SHALL give rst priority over all inputs; pushes and pops in a reset cycle are discarded; stored entries are lost on reset mid-operation.

Configuration
REQ-031 SHALL, when macro DELETE_QUEUE_STATS_EN is defined, add outputs accepted_count (32) and dropped_count (32): saturating counters of pushes stored and pushes dropped on full, both reset to 0.
REQ-032 SHALL, when DELETE_QUEUE_STATS_EN is undefined, omit both ports and counters with all other behaviour identical.

Verification
REQ-033 SHALL verify: reset, then one pulse with ref 0x0000_0000_DEAD_BEEF at cycle 5 of the timestamp counter, out_ready=1 -> out_valid high one cycle, out_order_ref=0xDEADBEEF, out_timestamp=5, level returns to 0.
REQ-034 SHALL verify: 8 pushes with refs 1..8, out_ready=0, then a 9th with ref 9 -> level=8, overflow=1, drained order 1..8, ref 9 absent, dropped_count=1 with DELETE_QUEUE_STATS_EN.
REQ-035 SHALL verify: full queue, push ref 0xAA with out_ready=1 in the same cycle -> head ref 1 popped, 0xAA stored last, level stays 8, overflow stays 0.
REQ-036 SHALL verify: delete_internal_valid=1 with delete_packet_invalid=1, ref 0x55 -> no entry, level=0, overflow=0.
REQ-037 SHALL verify: 20 push/pop cycles streaming refs 0..19 with level near 3 -> pointer wrap is exercised and output order is 0..19 with no loss.
REQ-038 SHALL verify: rst asserted with level=5 and a push in the same cycle -> next cycle level=0, out_valid=0, overflow=0, timestamp counter=0.
